fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Write-side companion to the 640x480 1bpp VGA scan-out, which reads 32-bit framebuffer words with bits sent MSB-first (bit 31 = leftmost pixel).
- Accepts single-pixel plot requests and whole-screen clear commands from the CPU/bus side.
- Turns each plot into a read-modify-write on the framebuffer's 32-bit memory port.
- Sits between the CPU MMIO decoder and the write port of the dual-port framebuffer RAM.

Parameters:
- HVALID, 640, visible pixels per line
- VVALID, 480, visible lines
- WORDS_PER_LINE, 20, HVALID/32
- FB_WORDS, 9600, WORDS_PER_LINE*VVALID
- ADDR_W, 14, framebuffer word-address width

Ports:
- CLK  in  1  system clock; framebuffer port is synchronous to CLK
- reset  in  1  asynchronous, active-high
- px_valid  in  1  plot request valid
- px_ready  out  1  plot/clear accepted this cycle when high with the matching valid
- px_x  in  10  pixel column
- px_y  in  9  pixel row
- px_color  in  1  pixel value
- clr_valid  in  1  clear-screen request
- clr_color  in  1  fill value for the clear
- busy  out  1  high while not in IDLE
- done  out  1  one-cycle pulse when a plot or clear completes
- oob  out  1  one-cycle pulse when an out-of-range plot is dropped
- mem_addr  out  ADDR_W  framebuffer word address
- mem_wdata  out  32  write data
- mem_we  out  1  write enable
- mem_rdata  in  32  read data, valid one cycle after mem_addr is presented with mem_we=0

Behaviour:
- Reset values: all outputs 0, except px_ready=1; FSM in IDLE; clear counter 0. Reset mid-operation aborts immediately. No partial write is completed. mem_we drops asynchronously.
- FSM states: IDLE, RD, WR, CLR.
- IDLE:
  - px_ready=1, busy=0.
  - clr_valid has priority over px_valid in the same cycle. The pixel request is not accepted; px_ready refers to the clear.
  - Accept clear: latch clr_color, counter=0, go to CLR.
  - Accept plot with px_x>=HVALID or px_y>=VVALID: drop it, pulse oob next cycle, stay IDLE, no memory access.
  - Accept in-range plot: latch word address = px_y*20 + px_x[9:5], computed as (y<<4)+(y<<2)+x[9:5] in 14 bits (max 9599). Latch bit index = 31 - px_x[4:0], and px_color. Go to RD.
- RD: mem_addr=latched address, mem_we=0, px_ready=0. Next state WR.
- WR:
  - mem_addr held; mem_wdata = mem_rdata with the indexed bit replaced by the color; mem_we=1.
  - All other 31 bits pass through unchanged.
  - Pulse done next cycle; go to IDLE.
- Plot throughput: accept to write strobe = 2 cycles; next accept possible 3 cycles after the previous one.
- CLR:
  - mem_we=1, mem_wdata = 32 copies of the fill color, mem_addr=counter, counter increments each cycle.
  - Writes addresses 0..FB_WORDS-1 in order, exactly FB_WORDS cycles.
  - After writing address 9599: go to IDLE, pulse done, counter returns to 0 with no wrap write to 0.
  - Requests arriving during CLR are ignored (px_ready=0). The requester must hold valid.
- Outputs driven from registered state. mem_we never asserts in IDLE.
- The scan-out reads the other RAM port concurrently. Read/write collision on the same word is tolerated; one frame of staleness is acceptable.

Decomposition:
- Shared package fb_pkg: HVALID, VVALID, WORDS_PER_LINE, FB_WORDS, ADDR_W, and the FSM state encoding. The VGA scan-out's 9600 wrap constant moves to this package too.
- One natural sub-module fb_addr_calc: combinational (x,y) -> {word address, bit index, out_of_range}. It is reusable by a future character/sprite writer.

Test Plan:
- Clear with clr_color=0, then plot (0,0) color 1 → write to addr 0 of 32'h8000_0000, 2 cycles after accept; done pulses once.
- Model RAM preloaded with 32'hFFFF_FFFF at addr 9599; plot (639,479) color 0 → addr 9599 written 32'hFFFF_FFFE.
- Plot (640,0) and then (0,480) → no mem_we, oob pulses once each, px_ready stays 1.
- clr_color=1 → exactly 9600 consecutive writes of 32'hFFFF_FFFF to addr 0..9599; busy high 9600 cycles; done once.
- clr_valid and px_valid both high in IDLE → clear runs first. The held plot (35,2) then completes: addr 41, bit 28 cleared or set.
- Assert reset in RD state of a plot → mem_we never asserts; busy=0 and px_ready=1 during reset.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants for the 640x480 1bpp framebuffer: geometry, word addressing
// and the pixel-writer state encoding, common to the writer and the scan-out.
package fb_pkg;

   localparam int HVALID         = 640;
   localparam int VVALID         = 480;
   localparam int WORDS_PER_LINE = HVALID / 32;
   localparam int FB_WORDS       = WORDS_PER_LINE * VVALID;
   localparam int ADDR_W         = 14;

   // Last word address; the scan-out wraps after this word, the clear stops on it.
   localparam logic [ADDR_W-1:0] FB_LAST_ADDR = ADDR_W'(FB_WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_CLR  = 2'd3;

   // y*20 + x/32 using only shifts and adds, so no multiplier is needed.
   function automatic logic [ADDR_W-1:0] fbWordAddr(input logic [9:0] x,
                                                    input logic [8:0] y);
      logic [ADDR_W-1:0] yExt;
      yExt = ADDR_W'(y);
      return (yExt << 4) + (yExt << 2) + ADDR_W'(x[9:5]);
   endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to its framebuffer word, its bit inside that word
// (bit 31 is the leftmost pixel) and an out-of-range flag.
module fb_addr_calc
   import fb_pkg::*;
(
   input  logic [9:0]        i_x,
   input  logic [8:0]        i_y,
   output logic [ADDR_W-1:0] o_wordAddr,
   output logic [4:0]        o_bitIdx,
   output logic              o_outOfRange
);

   assign o_wordAddr   = fbWordAddr(i_x, i_y);
   assign o_bitIdx     = 5'd31 - i_x[4:0];
   assign o_outOfRange = (i_x >= 10'(HVALID)) || (i_y >= 9'(VVALID));

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write side: single-pixel plots as read-modify-write of one 32-bit
// word, and whole-screen clears, driven onto the RAM's write port.
module fb_pixel_writer
   import fb_pkg::*;
(
   input  logic              CLK,
   input  logic              reset,
   input  logic              i_px_valid,
   output logic              o_px_ready,
   input  logic [9:0]        i_px_x,
   input  logic [8:0]        i_px_y,
   input  logic              i_px_color,
   input  logic              i_clr_valid,
   input  logic              i_clr_color,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_oob,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_mem_we,
   input  logic [31:0]       i_mem_rdata
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [4:0]        r_bitIdx;
   logic              r_color;
   logic              r_clrColor;
   logic [ADDR_W-1:0] r_count;
   logic              r_done;
   logic              r_oob;

   logic [ADDR_W-1:0] w_wordAddr;
   logic [4:0]        w_bitIdx;
   logic              w_outOfRange;
   logic [31:0]       w_bitMask;

   fb_addr_calc u_addrCalc (
      .i_x          (i_px_x),
      .i_y          (i_px_y),
      .o_wordAddr   (w_wordAddr),
      .o_bitIdx     (w_bitIdx),
      .o_outOfRange (w_outOfRange)
   );

   // Control FSM: a clear wins over a plot offered in the same cycle, and the
   // plot stays pending on the requester side until the writer is idle again.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_bitIdx   <= '0;
         r_color    <= 1'b0;
         r_clrColor <= 1'b0;
         r_count    <= '0;
         r_done     <= 1'b0;
         r_oob      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_oob  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_clr_valid) begin
                  r_clrColor <= i_clr_color;
                  r_count    <= '0;
                  r_state    <= S_CLR;
               end else if (i_px_valid) begin
                  if (w_outOfRange) begin
                     r_oob <= 1'b1;
                  end else begin
                     r_addr   <= w_wordAddr;
                     r_bitIdx <= w_bitIdx;
                     r_color  <= i_px_color;
                     r_state  <= S_RD;
                  end
               end
            end
            S_RD: begin
               r_state <= S_WR;
            end
            S_WR: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            S_CLR: begin
               if (r_count == FB_LAST_ADDR) begin
                  r_count <= '0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_bitMask = 32'd1 << r_bitIdx;

   // Memory port decode from the state register alone, so an asynchronous
   // reset removes the write strobe at once.  In WR the read word returned
   // for the RD address is merged with the new pixel.
   always_comb begin
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_we    = 1'b0;
      case (r_state)
         S_RD: begin
            o_mem_addr = r_addr;
         end
         S_WR: begin
            o_mem_addr  = r_addr;
            o_mem_we    = 1'b1;
            o_mem_wdata = (i_mem_rdata & ~w_bitMask) | (r_color ? w_bitMask : 32'd0);
         end
         S_CLR: begin
            o_mem_addr  = r_count;
            o_mem_we    = 1'b1;
            o_mem_wdata = {32{r_clrColor}};
         end
         default: begin
         end
      endcase
   end

   assign o_px_ready = (r_state == S_IDLE);
   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;
   assign o_oob      = r_oob;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: a RAM model with one-cycle read
// latency plus a pixel-level shadow framebuffer that predicts every word.
module tb_fb_pixel_writer;
   import fb_pkg::*;

   logic              CLK = 1'b0;
   logic              reset;
   logic              pxValid;
   logic              pxReady;
   logic [9:0]        pxX;
   logic [8:0]        pxY;
   logic              pxColor;
   logic              clrValid;
   logic              clrColor;
   logic              busy;
   logic              done;
   logic              oob;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWdata;
   logic              memWe;
   logic [31:0]       memRdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0]       ram [0:FB_WORDS-1];
   logic              preloadReq = 1'b0;
   logic [ADDR_W-1:0] preloadAddr = '0;
   logic [31:0]       preloadData = '0;

   bit shadow [0:VVALID-1][0:HVALID-1];

   typedef struct {
      logic              accepted;
      logic              rdWe;
      logic [ADDR_W-1:0] rdAddr;
      logic              readyK1;
      int                wrCycle;
      logic [ADDR_W-1:0] wrAddr;
      logic [31:0]       wrData;
      int                weCount;
      int                doneCycle;
      int                doneCount;
      int                oobCycle;
      int                oobCount;
   } plotObs_t;

   always #5 CLK = ~CLK;

   fb_pixel_writer dut (
      .CLK         (CLK),
      .reset       (reset),
      .i_px_valid  (pxValid),
      .o_px_ready  (pxReady),
      .i_px_x      (pxX),
      .i_px_y      (pxY),
      .i_px_color  (pxColor),
      .i_clr_valid (clrValid),
      .i_clr_color (clrColor),
      .o_busy      (busy),
      .o_done      (done),
      .o_oob       (oob),
      .o_mem_addr  (memAddr),
      .o_mem_wdata (memWdata),
      .o_mem_we    (memWe),
      .i_mem_rdata (memRdata)
   );

   // Framebuffer RAM model: synchronous write, registered read.
   always @(posedge CLK) begin
      if (preloadReq)
         ram[preloadAddr] <= preloadData;
      else if (memWe && memAddr < 14'(FB_WORDS))
         ram[memAddr] <= memWdata;
      if (memAddr < 14'(FB_WORDS))
         memRdata <= ram[memAddr];
      else
         memRdata <= 32'hDEAD_BEEF;
   end

   // Expected word content rebuilt from individual pixels, leftmost in bit 31.
   function automatic logic [31:0] expWord(input int addr);
      int row;
      int col0;
      logic [31:0] w;
      row  = addr / WORDS_PER_LINE;
      col0 = (addr % WORDS_PER_LINE) * 32;
      for (int k = 0; k < 32; k++) w[31-k] = shadow[row][col0+k];
      return w;
   endfunction

   task automatic fillShadow(input bit c);
      for (int r = 0; r < VVALID; r++)
         for (int col = 0; col < HVALID; col++) shadow[r][col] = c;
   endtask

   task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input logic c,
                                output plotObs_t o);
      int guard;
      o.accepted = 1'b0; o.rdWe = 1'b0; o.rdAddr = '0; o.readyK1 = 1'b0;
      o.wrCycle = -1; o.wrAddr = '0; o.wrData = '0; o.weCount = 0;
      o.doneCycle = -1; o.doneCount = 0; o.oobCycle = -1; o.oobCount = 0;
      @(negedge CLK);
      pxX = x; pxY = y; pxColor = c; pxValid = 1'b1;
      guard = 0;
      while (!pxReady && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      o.accepted = pxReady;
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            o.rdWe = memWe; o.rdAddr = memAddr; o.readyK1 = pxReady;
            pxValid = 1'b0;
         end
         if (memWe) begin
            if (o.wrCycle < 0) begin
               o.wrCycle = k; o.wrAddr = memAddr; o.wrData = memWdata;
            end
            o.weCount++;
         end
         if (done) begin
            if (o.doneCycle < 0) o.doneCycle = k;
            o.doneCount++;
         end
         if (oob) begin
            if (o.oobCycle < 0) o.oobCycle = k;
            o.oobCount++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pxValid = 1'b0; pxX = '0; pxY = '0; pxColor = 1'b0;
      clrValid = 1'b0; clrColor = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (pxReady !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || oob !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_handshake: ready=%b busy=%b done=%b oob=%b, required 1 0 0 0",
                  pxReady, busy, done, oob);
      end
      checks++;
      if (memWe !== 1'b0 || memAddr !== '0 || memWdata !== '0) begin
         failures++;
         $display("[TB] FAIL reset_mem: we=%b addr=%0d wdata=%h, required 0 0 0",
                  memWe, memAddr, memWdata);
      end
      reset = 1'b0;
      @(negedge CLK);
      checks++;
      if (pxReady !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL post_reset_idle: ready=%b busy=%b, required 1 0", pxReady, busy);
      end
   endtask

   task automatic test_clear(input logic c);
      int nW, bad, firstBadK, busyN, readyBad, doneN, firstK, lastK, ramBad;
      nW = 0; bad = 0; firstBadK = -1; busyN = 0; readyBad = 0; doneN = 0;
      firstK = -1; lastK = -1; ramBad = 0;
      @(negedge CLK);
      clrColor = c; clrValid = 1'b1;
      for (int k = 1; k <= FB_WORDS + 10; k++) begin
         @(negedge CLK);
         if (memWe) begin
            if (memAddr !== 14'(nW) || memWdata !== {32{c}}) begin
               if (bad == 0) firstBadK = k;
               bad++;
            end
            if (firstK < 0) firstK = k;
            lastK = k;
            nW++;
         end
         if (busy) busyN++;
         if (busy && pxReady) readyBad++;
         if (done) doneN++;
         if (k == 1) begin
            clrValid = 1'b0; clrColor = ~c;
         end
      end
      fillShadow(c);
      checks++;
      if (nW != FB_WORDS || bad != 0 || firstK != 1 || lastK != FB_WORDS) begin
         failures++;
         $display("[TB] FAIL clear_writes c=%b: writes=%0d bad=%0d (first bad cycle %0d) span %0d..%0d, required %0d 0 1..%0d",
                  c, nW, bad, firstBadK, firstK, lastK, FB_WORDS, FB_WORDS);
      end
      checks++;
      if (busyN != FB_WORDS || readyBad != 0 || doneN != 1) begin
         failures++;
         $display("[TB] FAIL clear_status c=%b: busy cycles=%0d ready-while-busy=%0d done=%0d, required %0d 0 1",
                  c, busyN, readyBad, doneN, FB_WORDS);
      end
      for (int a = 0; a < FB_WORDS; a++) if (ram[a] !== expWord(a)) ramBad++;
      checks++;
      if (ramBad != 0) begin
         failures++;
         $display("[TB] FAIL clear_ram c=%b: %0d words differ, required 0", c, ramBad);
      end
   endtask

   task automatic test_corner_plots();
      plotObs_t o;
      logic [31:0] expD;
      applyStimulus(10'd0, 9'd0, 1'b1, o);
      shadow[0][0] = 1'b1;
      expD = expWord(0);
      checks++;
      if (!o.accepted || o.wrCycle != 2 || o.wrAddr !== 14'd0 || o.wrData !== expD ||
          o.weCount != 1 || o.doneCount != 1 || o.doneCycle != 3 || o.rdWe !== 1'b0) begin
         failures++;
         $display("[TB] FAIL plot_0_0: acc=%b wr@%0d addr=%0d data=%h we=%0d done=%0d@%0d rdWe=%b, required 1 2 0 %h 1 1@3 0",
                  o.accepted, o.wrCycle, o.wrAddr, o.wrData, o.weCount, o.doneCount, o.doneCycle, o.rdWe, expD);
      end

      @(negedge CLK);
      preloadAddr = 14'(FB_WORDS - 1); preloadData = 32'hFFFF_FFFF; preloadReq = 1'b1;
      @(posedge CLK);
      #1 preloadReq = 1'b0;
      for (int col = HVALID - 32; col < HVALID; col++) shadow[VVALID-1][col] = 1'b1;
      applyStimulus(10'd639, 9'd479, 1'b0, o);
      shadow[VVALID-1][HVALID-1] = 1'b0;
      expD = expWord(FB_WORDS - 1);
      checks++;
      if (!o.accepted || o.wrCycle != 2 || o.wrAddr !== 14'(FB_WORDS - 1) || o.wrData !== expD ||
          o.weCount != 1 || o.doneCount != 1) begin
         failures++;
         $display("[TB] FAIL plot_639_479: acc=%b wr@%0d addr=%0d data=%h we=%0d done=%0d, required 1 2 %0d %h 1 1",
                  o.accepted, o.wrCycle, o.wrAddr, o.wrData, o.weCount, o.doneCount, FB_WORDS - 1, expD);
      end
      checks++;
      if (ram[FB_WORDS-1] !== expD) begin
         failures++;
         $display("[TB] FAIL ram_9599: got %h, required %h", ram[FB_WORDS-1], expD);
      end
   endtask

   task automatic test_oob();
      plotObs_t o;
      applyStimulus(10'd640, 9'd0, 1'b1, o);
      checks++;
      if (!o.accepted || o.weCount != 0 || o.oobCount != 1 || o.oobCycle != 1 ||
          o.doneCount != 0 || o.readyK1 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL oob_x640: acc=%b we=%0d oob=%0d@%0d done=%0d ready=%b, required 1 0 1@1 0 1",
                  o.accepted, o.weCount, o.oobCount, o.oobCycle, o.doneCount, o.readyK1);
      end
      applyStimulus(10'd0, 9'd480, 1'b1, o);
      checks++;
      if (!o.accepted || o.weCount != 0 || o.oobCount != 1 || o.oobCycle != 1 ||
          o.doneCount != 0 || o.readyK1 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL oob_y480: acc=%b we=%0d oob=%0d@%0d done=%0d ready=%b, required 1 0 1@1 0 1",
                  o.accepted, o.weCount, o.oobCount, o.oobCycle, o.doneCount, o.readyK1);
      end
   endtask

   task automatic test_random_plots();
      plotObs_t o;
      logic [9:0] x;
      logic [8:0] y;
      logic c;
      int expA;
      logic [31:0] expD;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               x = 10'($urandom_range(640, 1023)); y = 9'($urandom_range(0, 511));
            end else begin
               x = 10'($urandom_range(0, 1023));   y = 9'($urandom_range(480, 511));
            end
         end else begin
            x = 10'($urandom_range(0, 639)); y = 9'($urandom_range(0, 479));
         end
         c = 1'($urandom_range(0, 1));
         applyStimulus(x, y, c, o);
         checks++;
         if (int'(x) < HVALID && int'(y) < VVALID) begin
            shadow[y][x] = c;
            expA = int'(y) * WORDS_PER_LINE + int'(x) / 32;
            expD = expWord(expA);
            if (!o.accepted || o.wrCycle != 2 || o.wrAddr !== 14'(expA) || o.rdAddr !== 14'(expA) ||
                o.wrData !== expD || o.weCount != 1 || o.doneCount != 1 || o.doneCycle != 3 ||
                o.oobCount != 0 || o.readyK1 !== 1'b0) begin
               failures++;
               $display("[TB] FAIL rand_plot (%0d,%0d,%b): wr@%0d addr=%0d rd=%0d data=%h we=%0d done=%0d@%0d oob=%0d, required 2 %0d %0d %h 1 1@3 0",
                        x, y, c, o.wrCycle, o.wrAddr, o.rdAddr, o.wrData, o.weCount, o.doneCount,
                        o.doneCycle, o.oobCount, expA, expA, expD);
            end
         end else begin
            if (!o.accepted || o.weCount != 0 || o.oobCount != 1 || o.doneCount != 0) begin
               failures++;
               $display("[TB] FAIL rand_oob (%0d,%0d): we=%0d oob=%0d done=%0d, required 0 1 0",
                        x, y, o.weCount, o.oobCount, o.doneCount);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] x1, x2;
      logic [8:0] y1, y2;
      logic c1, c2;
      int a1, a2, secondK, nW, doneN;
      int wK [0:1];
      logic [ADDR_W-1:0] wA [0:1];
      logic [31:0] wD [0:1];
      logic [31:0] e1, e2;
      x1 = 10'($urandom_range(0, 639)); y1 = 9'($urandom_range(0, 479)); c1 = 1'($urandom_range(0, 1));
      x2 = 10'($urandom_range(0, 639)); y2 = 9'($urandom_range(0, 479)); c2 = 1'($urandom_range(0, 1));
      a1 = int'(y1) * WORDS_PER_LINE + int'(x1) / 32;
      a2 = int'(y2) * WORDS_PER_LINE + int'(x2) / 32;
      shadow[y1][x1] = c1; e1 = expWord(a1);
      shadow[y2][x2] = c2; e2 = expWord(a2);
      secondK = -1; nW = 0; doneN = 0;
      wK[0] = -1; wK[1] = -1; wA[0] = '0; wA[1] = '0; wD[0] = '0; wD[1] = '0;
      @(negedge CLK);
      pxX = x1; pxY = y1; pxColor = c1; pxValid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge CLK);
         if (memWe) begin
            if (nW < 2) begin
               wK[nW] = k; wA[nW] = memAddr; wD[nW] = memWdata;
            end
            nW++;
         end
         if (done) doneN++;
         if (secondK >= 0 && k == secondK + 1) pxValid = 1'b0;
         else if (k > 1 && secondK < 0 && pxValid && pxReady) secondK = k;
         if (k == 1) begin
            pxX = x2; pxY = y2; pxColor = c2;
         end
      end
      pxValid = 1'b0;
      checks++;
      if (secondK != 3 || nW != 2 || doneN != 2) begin
         failures++;
         $display("[TB] FAIL b2b_timing: second accept@%0d writes=%0d done=%0d, required 3 2 2",
                  secondK, nW, doneN);
      end
      checks++;
      if (wK[0] != 2 || wA[0] !== 14'(a1) || wD[0] !== e1 ||
          wK[1] != 5 || wA[1] !== 14'(a2) || wD[1] !== e2) begin
         failures++;
         $display("[TB] FAIL b2b_data: w0@%0d %0d=%h w1@%0d %0d=%h, required 2 %0d=%h 5 %0d=%h",
                  wK[0], wA[0], wD[0], wK[1], wA[1], wD[1], a1, e1, a2, e2);
      end
   endtask

   task automatic test_clear_priority();
      int nW, doneN, acceptK;
      logic [ADDR_W-1:0] fA, lA;
      logic [31:0] fD, lD, expD;
      bit dropNext;
      nW = 0; doneN = 0; acceptK = -1; dropNext = 0;
      fA = '0; lA = '0; fD = '0; lD = '0;
      @(negedge CLK);
      clrValid = 1'b1; clrColor = 1'b1;
      pxX = 10'd35; pxY = 9'd2; pxColor = 1'b0; pxValid = 1'b1;
      for (int k = 1; k <= FB_WORDS + 20; k++) begin
         @(negedge CLK);
         if (memWe) begin
            if (nW == 0) begin
               fA = memAddr; fD = memWdata;
            end
            lA = memAddr; lD = memWdata;
            nW++;
         end
         if (done) doneN++;
         if (k == 1) clrValid = 1'b0;
         if (dropNext) begin
            pxValid = 1'b0; dropNext = 0;
         end else if (pxValid && pxReady && acceptK < 0) begin
            acceptK = k; dropNext = 1;
         end
      end
      pxValid = 1'b0;
      fillShadow(1'b1);
      shadow[2][35] = 1'b0;
      expD = expWord(2 * WORDS_PER_LINE + 35 / 32);
      checks++;
      if (fA !== 14'd0 || fD !== 32'hFFFF_FFFF || acceptK != FB_WORDS + 1 || nW != FB_WORDS + 1 || doneN != 2) begin
         failures++;
         $display("[TB] FAIL priority_order: first %0d=%h plot accept@%0d writes=%0d done=%0d, required 0=ffffffff %0d %0d 2",
                  fA, fD, acceptK, nW, doneN, FB_WORDS + 1, FB_WORDS + 1);
      end
      checks++;
      if (lA !== 14'd41 || lD !== expD) begin
         failures++;
         $display("[TB] FAIL priority_plot: last write %0d=%h, required 41=%h", lA, lD, expD);
      end
   endtask

   task automatic test_reset_mid_plot();
      logic c;
      int weSeen, addr, statusBad;
      logic busyInRd;
      c = ~shadow[50][100];
      addr = 50 * WORDS_PER_LINE + 100 / 32;
      weSeen = 0; statusBad = 0;
      @(negedge CLK);
      pxX = 10'd100; pxY = 9'd50; pxColor = c; pxValid = 1'b1;
      @(negedge CLK);
      busyInRd = busy;
      if (memWe) weSeen++;
      reset = 1'b1; pxValid = 1'b0;
      #1;
      checks++;
      if (busyInRd !== 1'b1 || pxReady !== 1'b1 || busy !== 1'b0 || memWe !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_in_rd: busy before=%b ready=%b busy=%b we=%b done=%b, required 1 1 0 0 0",
                  busyInRd, pxReady, busy, memWe, done);
      end
      repeat (3) begin
         @(negedge CLK);
         if (memWe) weSeen++;
         if (pxReady !== 1'b1 || busy !== 1'b0) statusBad++;
      end
      reset = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         if (memWe) weSeen++;
      end
      checks++;
      if (weSeen != 0 || statusBad != 0) begin
         failures++;
         $display("[TB] FAIL reset_abort: write strobes=%0d bad status cycles=%0d, required 0 0",
                  weSeen, statusBad);
      end
      checks++;
      if (ram[addr] !== expWord(addr)) begin
         failures++;
         $display("[TB] FAIL reset_abort_ram: word %0d=%h, required %h", addr, ram[addr], expWord(addr));
      end
   endtask

   initial begin
      test_reset();
      test_clear(1'b0);
      test_corner_plots();
      test_oob();
      test_random_plots();
      test_back_to_back();
      test_clear(1'b1);
      test_clear_priority();
      test_reset_mid_plot();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
